// File: rtl/ristretto_pipe_ctrl.sv
// Pipeline control for the ristretto core: load-use bubbles, memory-busy freeze,
// fixed-length redirect flush, trap front-end hold and a saturating lost-cycle counter.
module ristretto_pipe_ctrl #(
    parameter int DataWidth   = 32,
    parameter int FlushCycles = 2
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic [4:0]           dec_rs1_addr_i,
    input  logic                 dec_rs1_used_i,
    input  logic [4:0]           dec_rs2_addr_i,
    input  logic                 dec_rs2_used_i,
    input  logic                 dec_valid_i,
    input  logic                 exe_valid_i,
    input  logic [4:0]           exe_rd_addr_i,
    input  logic                 exe_is_load_i,
    input  logic                 exe_redirect_i,
    input  logic                 exe_exception_i,
    input  logic                 mem_busy_i,
    input  logic                 trap_ack_i,
    input  logic                 cnt_clear_i,
    output logic                 if_dec_stall_o,
    output logic                 dec_exe_stall_o,
    output logic                 exe_wb_stall_o,
    output logic                 if_dec_flush_o,
    output logic                 dec_exe_flush_o,
    output logic                 exe_wb_flush_o,
    output logic                 trap_o,
    output logic [DataWidth-1:0] lost_cycles_o
);

    typedef enum logic [1:0] {RUN, FLUSH, TRAP} state_t;

    localparam logic [1:0] FLUSH_INIT = 2'(FlushCycles - 1);

    state_t               state, state_nxt;
    logic [1:0]           fcnt, fcnt_nxt;
    logic                 trap_q;
    logic [DataWidth-1:0] lost_q;
    logic                 load_use, redir, exc, lost_evt;

    function automatic logic [DataWidth-1:0] sat_inc(input logic [DataWidth-1:0] v);
        return (&v) ? v : v + DataWidth'(1);
    endfunction

    assign load_use = dec_valid_i & exe_valid_i & exe_is_load_i & (exe_rd_addr_i != 5'd0) &
                      ((dec_rs1_used_i & (dec_rs1_addr_i == exe_rd_addr_i)) |
                       (dec_rs2_used_i & (dec_rs2_addr_i == exe_rd_addr_i)));
    assign redir    = exe_valid_i & exe_redirect_i;
    assign exc      = exe_valid_i & exe_exception_i;
    assign lost_evt = dec_exe_stall_o | dec_exe_flush_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state  <= RUN;
            fcnt   <= 2'd0;
            trap_q <= 1'b0;
        end else begin
            state  <= state_nxt;
            fcnt   <= fcnt_nxt;
            trap_q <= (state_nxt == TRAP);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i)            lost_q <= '0;
        else if (cnt_clear_i) lost_q <= '0;
        else if (lost_evt)    lost_q <= sat_inc(lost_q);
    end

    always_comb begin
        state_nxt = state;
        fcnt_nxt  = fcnt;
        case (state)
            RUN: begin
                if (!mem_busy_i) begin
                    if (exc) begin
                        state_nxt = TRAP;
                    end else if (redir && (FlushCycles > 1)) begin
                        state_nxt = FLUSH;
                        fcnt_nxt  = FLUSH_INIT;
                    end
                end
            end
            FLUSH: begin
                // The redirect cycle itself was the first flush, so fcnt == 1 marks the last one.
                if (!mem_busy_i) begin
                    fcnt_nxt = fcnt - 2'd1;
                    if (fcnt == 2'd1) state_nxt = RUN;
                end
            end
            TRAP: begin
                if (trap_ack_i) state_nxt = RUN;
            end
            default: begin
                state_nxt = RUN;
                fcnt_nxt  = 2'd0;
            end
        endcase
    end

    always_comb begin
        if_dec_stall_o  = 1'b0;
        dec_exe_stall_o = 1'b0;
        exe_wb_stall_o  = 1'b0;
        if_dec_flush_o  = 1'b0;
        dec_exe_flush_o = 1'b0;
        exe_wb_flush_o  = 1'b0;
        if (!rst_i) begin
            case (state)
                RUN: begin
                    if (mem_busy_i) begin
                        if_dec_stall_o  = 1'b1;
                        dec_exe_stall_o = 1'b1;
                        exe_wb_stall_o  = 1'b1;
                    end else if (exc) begin
                        if_dec_flush_o  = 1'b1;
                        dec_exe_flush_o = 1'b1;
                        exe_wb_flush_o  = 1'b1;
                    end else if (redir) begin
                        if_dec_flush_o  = 1'b1;
                        dec_exe_flush_o = 1'b1;
                    end else if (load_use) begin
                        if_dec_stall_o  = 1'b1;
                        dec_exe_flush_o = 1'b1;
                    end
                end
                FLUSH: begin
                    if (mem_busy_i) begin
                        if_dec_stall_o  = 1'b1;
                        dec_exe_stall_o = 1'b1;
                        exe_wb_stall_o  = 1'b1;
                    end else begin
                        if_dec_flush_o  = 1'b1;
                        dec_exe_flush_o = 1'b1;
                    end
                end
                TRAP: begin
                    if_dec_flush_o  = 1'b1;
                    dec_exe_flush_o = 1'b1;
                    exe_wb_stall_o  = mem_busy_i;
                end
                default: ;
            endcase
        end
    end

    assign trap_o        = trap_q;
    assign lost_cycles_o = lost_q;

endmodule
